// File: rtl/game_round_ctrl.sv
// Round controller for the factorization quiz: READY -> QUESTION -> INPUT, timed result holds, HP tracking.
// Optional macro ROUND_CNT_EN adds a saturating ROUND_CNT output counting scored rounds.
module game_round_ctrl #(
   parameter int HOLD_CYCLES = 8,
   parameter int TMO_CYCLES  = 64,
   parameter int MAX_WRONG   = 3,
   parameter int HP_INIT     = 3,
   parameter int HP_W        = 3
) (
   input  logic                           CLK,
   input  logic                           RST_N,
   input  logic                           START,
   input  logic                           QUE_VALID,
   input  logic                           QUE_ACK,
   input  logic                           ANS_VALID,
   input  logic [1:0]                     ANS_CODE,
   output logic [3:0]                     STATE,
   output logic                           QUE_REQ,
   output logic                           INPUT_EN,
   output logic                           HOLD_ACTIVE,
   output logic [HP_W-1:0]                HP_P,
   output logic [HP_W-1:0]                HP_E,
   output logic [$clog2(MAX_WRONG+1)-1:0] WRONG_CNT
`ifdef ROUND_CNT_EN
   ,
   output logic [7:0]                     ROUND_CNT
`endif
);

   localparam int WW  = $clog2(MAX_WRONG + 1);
   localparam int HCW = $clog2(HOLD_CYCLES + 1);
   localparam int TCW = $clog2(TMO_CYCLES + 1);

   localparam logic [HCW-1:0]  HOLD_LAST = HCW'(HOLD_CYCLES - 1);
   localparam logic [TCW-1:0]  TMO_LAST  = TCW'(TMO_CYCLES - 1);
   localparam logic [WW-1:0]   WRONG_LIM = WW'(MAX_WRONG);
   localparam logic [HP_W-1:0] HP_RST    = HP_W'(HP_INIT);

   typedef enum logic [3:0] {
      ST_READY    = 4'b0010,
      ST_QUESTION = 4'b0011,
      ST_INPUT    = 4'b0100,
      ST_DRAW     = 4'b0110,
      ST_WRONG    = 4'b0111,
      ST_GOOD     = 4'b1000,
      ST_OUCH     = 4'b1001,
      ST_WIN      = 4'b1010,
      ST_LOSE     = 4'b1011
   } state_t;

   function automatic logic is_result(input state_t s);
      logic r;
      case (s)
         ST_WRONG, ST_GOOD, ST_OUCH, ST_DRAW, ST_WIN, ST_LOSE: r = 1'b1;
         default:                                              r = 1'b0;
      endcase
      return r;
   endfunction

   state_t          state_r;
   state_t          next_s;
   logic            que_req_r;
   logic            input_en_r;
   logic            hold_active_r;
   logic [HP_W-1:0] hp_p_r;
   logic [HP_W-1:0] hp_e_r;
   logic [WW-1:0]   wrong_cnt_r;
   logic [TCW-1:0]  tmo_cnt_r;
   logic [HCW-1:0]  hold_cnt_r;

   logic que_go_s;
   logic clr_wrong_s;
   logic wrong_inc_s;
   logic dec_p_s;
   logic dec_e_s;
   logic reload_s;
   logic round_inc_s;
   logic hold_done_s;
   logic tmo_done_s;

   assign hold_done_s = (hold_cnt_r == HOLD_LAST);
   assign tmo_done_s  = (tmo_cnt_r == TMO_LAST);

   // Next-state decode and per-edge update strobes
   always_comb begin
      next_s      = state_r;
      que_go_s    = 1'b0;
      clr_wrong_s = 1'b0;
      wrong_inc_s = 1'b0;
      dec_p_s     = 1'b0;
      dec_e_s     = 1'b0;
      reload_s    = 1'b0;
      round_inc_s = 1'b0;
      case (state_r)
         ST_READY: begin
            if (START && QUE_VALID) begin
               next_s   = ST_QUESTION;
               que_go_s = 1'b1;
            end else begin
               next_s = ST_READY;
            end
         end
         ST_QUESTION: begin
            if (QUE_ACK) begin
               next_s      = ST_INPUT;
               clr_wrong_s = 1'b1;
            end else begin
               next_s = ST_QUESTION;
            end
         end
         ST_INPUT: begin
            // Abort beats a judged answer, which beats the timeout
            if (!QUE_ACK) begin
               next_s = ST_QUESTION;
            end else if (ANS_VALID) begin
               case (ANS_CODE)
                  2'b00: begin
                     wrong_inc_s = 1'b1;
                     if ((wrong_cnt_r + WW'(1)) == WRONG_LIM) begin
                        next_s  = ST_OUCH;
                        dec_p_s = 1'b1;
                     end else begin
                        next_s = ST_WRONG;
                     end
                  end
                  2'b01: begin
                     next_s  = ST_GOOD;
                     dec_e_s = 1'b1;
                  end
                  2'b10: begin
                     next_s  = ST_OUCH;
                     dec_p_s = 1'b1;
                  end
                  default: next_s = ST_DRAW;
               endcase
            end else if (tmo_done_s) begin
               next_s  = ST_OUCH;
               dec_p_s = 1'b1;
            end else begin
               next_s = ST_INPUT;
            end
         end
         ST_WRONG: begin
            if (hold_done_s) begin
               next_s = ST_INPUT;
            end else begin
               next_s = ST_WRONG;
            end
         end
         ST_GOOD: begin
            if (!hold_done_s) begin
               next_s = ST_GOOD;
            end else if (hp_e_r == {HP_W{1'b0}}) begin
               next_s = ST_WIN;
            end else begin
               next_s = ST_READY;
            end
         end
         ST_OUCH: begin
            if (!hold_done_s) begin
               next_s = ST_OUCH;
            end else if (hp_p_r == {HP_W{1'b0}}) begin
               next_s = ST_LOSE;
            end else begin
               next_s = ST_READY;
            end
         end
         ST_DRAW: begin
            if (hold_done_s) begin
               next_s = ST_READY;
            end else begin
               next_s = ST_DRAW;
            end
         end
         ST_WIN, ST_LOSE: begin
            if (hold_done_s) begin
               next_s   = ST_READY;
               reload_s = 1'b1;
            end else begin
               next_s = state_r;
            end
         end
         default: next_s = ST_READY;
      endcase
      if ((state_r == ST_INPUT) &&
          ((next_s == ST_GOOD) || (next_s == ST_OUCH) || (next_s == ST_DRAW))) begin
         round_inc_s = 1'b1;
      end else begin
         round_inc_s = 1'b0;
      end
   end

   // State register and registered status outputs, derived from the next state
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r       <= ST_READY;
         que_req_r     <= 1'b0;
         input_en_r    <= 1'b0;
         hold_active_r <= 1'b0;
      end else begin
         state_r       <= next_s;
         que_req_r     <= que_go_s;
         input_en_r    <= (next_s == ST_INPUT);
         hold_active_r <= is_result(next_s);
      end
   end

   // Timeout and hold counters restart whenever their state is (re)entered
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         tmo_cnt_r  <= {TCW{1'b0}};
         hold_cnt_r <= {HCW{1'b0}};
      end else begin
         if ((state_r == ST_INPUT) && (next_s == ST_INPUT)) begin
            tmo_cnt_r <= tmo_cnt_r + TCW'(1);
         end else begin
            tmo_cnt_r <= {TCW{1'b0}};
         end
         if (is_result(state_r) && (next_s == state_r)) begin
            hold_cnt_r <= hold_cnt_r + HCW'(1);
         end else begin
            hold_cnt_r <= {HCW{1'b0}};
         end
      end
   end

   // Wrong-answer count survives WRONG -> INPUT, cleared only from QUESTION
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wrong_cnt_r <= {WW{1'b0}};
      end else if (clr_wrong_s) begin
         wrong_cnt_r <= {WW{1'b0}};
      end else if (wrong_inc_s) begin
         wrong_cnt_r <= wrong_cnt_r + WW'(1);
      end else begin
         wrong_cnt_r <= wrong_cnt_r;
      end
   end

   // Hit points: saturating decrements, reloaded when WIN/LOSE ends
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         hp_p_r <= HP_RST;
         hp_e_r <= HP_RST;
      end else if (reload_s) begin
         hp_p_r <= HP_RST;
         hp_e_r <= HP_RST;
      end else begin
         if (dec_p_s && (hp_p_r != {HP_W{1'b0}})) begin
            hp_p_r <= hp_p_r - HP_W'(1);
         end else begin
            hp_p_r <= hp_p_r;
         end
         if (dec_e_s && (hp_e_r != {HP_W{1'b0}})) begin
            hp_e_r <= hp_e_r - HP_W'(1);
         end else begin
            hp_e_r <= hp_e_r;
         end
      end
   end

`ifdef ROUND_CNT_EN
   logic [7:0] round_cnt_r;

   // Scored-round counter, saturating, cleared at the end of a match
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         round_cnt_r <= 8'd0;
      end else if (reload_s) begin
         round_cnt_r <= 8'd0;
      end else if (round_inc_s && (round_cnt_r != 8'd255)) begin
         round_cnt_r <= round_cnt_r + 8'd1;
      end else begin
         round_cnt_r <= round_cnt_r;
      end
   end

   assign ROUND_CNT = round_cnt_r;
`endif

   assign STATE       = state_r;
   assign QUE_REQ     = que_req_r;
   assign INPUT_EN    = input_en_r;
   assign HOLD_ACTIVE = hold_active_r;
   assign HP_P        = hp_p_r;
   assign HP_E        = hp_e_r;
   assign WRONG_CNT   = wrong_cnt_r;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed self-checking bench for game_round_ctrl with default parameters.
module tb_game_round_ctrl;

   localparam logic [3:0] S_READY = 4'b0010;
   localparam logic [3:0] S_QUES  = 4'b0011;
   localparam logic [3:0] S_INPUT = 4'b0100;
   localparam logic [3:0] S_DRAW  = 4'b0110;
   localparam logic [3:0] S_WRONG = 4'b0111;
   localparam logic [3:0] S_GOOD  = 4'b1000;
   localparam logic [3:0] S_OUCH  = 4'b1001;
   localparam logic [3:0] S_WIN   = 4'b1010;
   localparam logic [3:0] S_LOSE  = 4'b1011;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       START = 1'b0;
   logic       QUE_VALID = 1'b0;
   logic       QUE_ACK = 1'b0;
   logic       ANS_VALID = 1'b0;
   logic [1:0] ANS_CODE = 2'b00;
   logic [3:0] STATE;
   logic       QUE_REQ;
   logic       INPUT_EN;
   logic       HOLD_ACTIVE;
   logic [2:0] HP_P;
   logic [2:0] HP_E;
   logic [1:0] WRONG_CNT;
`ifdef ROUND_CNT_EN
   logic [7:0] ROUND_CNT;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   game_round_ctrl dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .START       (START),
      .QUE_VALID   (QUE_VALID),
      .QUE_ACK     (QUE_ACK),
      .ANS_VALID   (ANS_VALID),
      .ANS_CODE    (ANS_CODE),
      .STATE       (STATE),
      .QUE_REQ     (QUE_REQ),
      .INPUT_EN    (INPUT_EN),
      .HOLD_ACTIVE (HOLD_ACTIVE),
      .HP_P        (HP_P),
      .HP_E        (HP_E),
      .WRONG_CNT   (WRONG_CNT)
`ifdef ROUND_CNT_EN
      ,
      .ROUND_CNT   (ROUND_CNT)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic check_round(input int exp);
`ifdef ROUND_CNT_EN
      check_val("round_cnt", 32'(ROUND_CNT), 32'(exp));
`endif
   endtask

   // READY -> QUESTION -> INPUT with QUE_ACK left high
   task automatic go_input();
      START = 1'b1; QUE_VALID = 1'b1; QUE_ACK = 1'b1;
      tick(1);
      check_val("goin_ques", 32'(STATE), 32'(S_QUES));
      START = 1'b0;
      tick(1);
      check_val("goin_input", 32'(STATE), 32'(S_INPUT));
      check_val("goin_en", 32'(INPUT_EN), 32'd1);
   endtask

   task automatic answer(input logic [1:0] code);
      ANS_VALID = 1'b1; ANS_CODE = code;
      tick(1);
      ANS_VALID = 1'b0;
   endtask

   initial begin
      tick(2);
      check_val("rst_state", 32'(STATE), 32'(S_READY));
      check_val("rst_hp_p", 32'(HP_P), 32'd3);
      check_val("rst_hp_e", 32'(HP_E), 32'd3);
      check_val("rst_wrong", 32'(WRONG_CNT), 32'd0);
      check_val("rst_req", 32'(QUE_REQ), 32'd0);
      check_val("rst_en", 32'(INPUT_EN), 32'd0);
      check_val("rst_hold", 32'(HOLD_ACTIVE), 32'd0);
      check_round(0);

      RST_N = 1'b1;
      tick(1);
      check_val("idle_ready", 32'(STATE), 32'(S_READY));
      START = 1'b1; QUE_VALID = 1'b1;
      tick(1);
      check_val("start_ques", 32'(STATE), 32'(S_QUES));
      check_val("start_req1", 32'(QUE_REQ), 32'd1);
      tick(1);
      check_val("ques_wait", 32'(STATE), 32'(S_QUES));
      check_val("start_req0", 32'(QUE_REQ), 32'd0);
      START = 1'b0; QUE_ACK = 1'b1;
      tick(1);
      check_val("first_input", 32'(STATE), 32'(S_INPUT));
      check_val("first_wrong", 32'(WRONG_CNT), 32'd0);

      // Three player hits drain the enemy and lead to WIN
      for (int r = 0; r < 3; r++) begin
         answer(2'b01);
         check_val("win_good", 32'(STATE), 32'(S_GOOD));
         check_val("win_hp_e", 32'(HP_E), 32'(2 - r));
         check_val("win_hold", 32'(HOLD_ACTIVE), 32'd1);
         check_round(r + 1);
         tick(7);
         check_val("win_good_held", 32'(STATE), 32'(S_GOOD));
         tick(1);
         if (r < 2) begin
            check_val("win_ready", 32'(STATE), 32'(S_READY));
            go_input();
         end else begin
            check_val("win_state", 32'(STATE), 32'(S_WIN));
            tick(7);
            check_val("win_held", 32'(STATE), 32'(S_WIN));
            tick(1);
            check_val("win_exit", 32'(STATE), 32'(S_READY));
            check_val("win_reload_p", 32'(HP_P), 32'd3);
            check_val("win_reload_e", 32'(HP_E), 32'd3);
            check_val("win_exit_hold", 32'(HOLD_ACTIVE), 32'd0);
            check_round(0);
         end
      end

      // Wrong-answer limit forces OUCH on the third malformed answer
      go_input();
      for (int w = 1; w <= 3; w++) begin
         answer(2'b00);
         if (w < 3) begin
            check_val("wl_wrong", 32'(STATE), 32'(S_WRONG));
            check_val("wl_cnt", 32'(WRONG_CNT), 32'(w));
            check_val("wl_en0", 32'(INPUT_EN), 32'd0);
            tick(8);
            check_val("wl_back", 32'(STATE), 32'(S_INPUT));
            check_val("wl_kept", 32'(WRONG_CNT), 32'(w));
         end else begin
            check_val("wl_ouch", 32'(STATE), 32'(S_OUCH));
            check_val("wl_hp_p", 32'(HP_P), 32'd2);
            check_val("wl_cnt3", 32'(WRONG_CNT), 32'd3);
            check_round(1);
         end
      end
      tick(8);
      check_val("wl_ready", 32'(STATE), 32'(S_READY));

      // Timeout after 64 silent cycles
      go_input();
      check_val("tmo_wclr", 32'(WRONG_CNT), 32'd0);
      tick(63);
      check_val("tmo_still", 32'(STATE), 32'(S_INPUT));
      tick(1);
      check_val("tmo_ouch", 32'(STATE), 32'(S_OUCH));
      check_val("tmo_hp_p", 32'(HP_P), 32'd1);
      check_round(2);
      tick(8);
      check_val("tmo_ready", 32'(STATE), 32'(S_READY));

      // Answer on the timeout cycle wins over the timeout
      go_input();
      tick(63);
      answer(2'b01);
      check_val("tmoa_good", 32'(STATE), 32'(S_GOOD));
      check_val("tmoa_hp_e", 32'(HP_E), 32'd2);
      check_val("tmoa_hp_p", 32'(HP_P), 32'd1);
      check_round(3);
      tick(8);
      check_val("tmoa_ready", 32'(STATE), 32'(S_READY));

      // Abort beats a same-cycle answer
      go_input();
      QUE_ACK = 1'b0;
      answer(2'b01);
      check_val("abort_ques", 32'(STATE), 32'(S_QUES));
      check_val("abort_hp_e", 32'(HP_E), 32'd2);
      check_val("abort_en", 32'(INPUT_EN), 32'd0);
      QUE_ACK = 1'b1;
      tick(1);
      check_val("abort_reenter", 32'(STATE), 32'(S_INPUT));

      // Draw, with START held through the hold for back-to-back restart
      answer(2'b11);
      START = 1'b1; QUE_VALID = 1'b1; QUE_ACK = 1'b0;
      check_val("draw_state", 32'(STATE), 32'(S_DRAW));
      check_val("draw_hp_p", 32'(HP_P), 32'd1);
      check_round(4);
      tick(7);
      check_val("draw_held", 32'(STATE), 32'(S_DRAW));
      tick(1);
      check_val("b2b_ready", 32'(STATE), 32'(S_READY));
      tick(1);
      check_val("b2b_ques", 32'(STATE), 32'(S_QUES));
      check_val("b2b_req", 32'(QUE_REQ), 32'd1);
      START = 1'b0; QUE_ACK = 1'b1;
      tick(1);
      check_val("b2b_input", 32'(STATE), 32'(S_INPUT));

      // Enemy hit drains the last player HP and leads to LOSE
      answer(2'b10);
      check_val("lose_ouch", 32'(STATE), 32'(S_OUCH));
      check_val("lose_hp_p", 32'(HP_P), 32'd0);
      check_round(5);
      tick(8);
      check_val("lose_state", 32'(STATE), 32'(S_LOSE));
      tick(7);
      check_val("lose_held", 32'(STATE), 32'(S_LOSE));
      tick(1);
      check_val("lose_exit", 32'(STATE), 32'(S_READY));
      check_val("lose_reload_p", 32'(HP_P), 32'd3);
      check_val("lose_reload_e", 32'(HP_E), 32'd3);
      check_round(0);

      // Asynchronous reset in the middle of a GOOD hold
      go_input();
      answer(2'b01);
      check_val("ar_good", 32'(STATE), 32'(S_GOOD));
      check_round(1);
      tick(4);
      #2;
      RST_N = 1'b0;
      #1;
      check_val("ar_state", 32'(STATE), 32'(S_READY));
      check_val("ar_hp_e", 32'(HP_E), 32'd3);
      check_val("ar_hold", 32'(HOLD_ACTIVE), 32'd0);
      check_val("ar_wrong", 32'(WRONG_CNT), 32'd0);
      check_round(0);
      tick(2);
      RST_N = 1'b1;
      tick(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
